// File: rtl/led_flow_ctrl.sv
// Stepped LED pattern controller: a toggle-level tick is synchronised, edge-detected
// and, after a post-reset settling window, advances a LEFT/RIGHT/BOUNCE/BLINK pattern.
module led_flow_ctrl #(
    parameter int LED_NUM     = 4,
    parameter int STARTUP_CYC = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               tick_in,
    input  logic [1:0]         mode,
    input  logic               pause,
    output logic [LED_NUM-1:0] led_out,
    output logic               step_pulse
);

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'b00,
        MODE_RIGHT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int                 CNT_W        = 4;
    localparam logic [CNT_W-1:0]   STARTUP_LAST = CNT_W'(STARTUP_CYC);
    localparam logic [LED_NUM-1:0] LED_LSB      = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] LED_MSB      = LED_LSB << (LED_NUM - 1);
    localparam logic [LED_NUM-1:0] LED_ALL      = {LED_NUM{1'b1}};

    logic               s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               pulse_q, pulse_d;
    mode_e              cur_mode_q, cur_mode_d;
    dir_e               dir_q, dir_d;

    logic               step_evt;
    logic               startup_done;
    logic               step_apply;
    mode_e              mode_in;

    assign step_evt     = s2_q ^ s3_q;
    assign startup_done = (cnt_q == STARTUP_LAST);
    assign step_apply   = step_evt & startup_done & ~pause;
    assign mode_in      = mode_e'(mode);

    // Synchroniser keeps running during the startup window so a level already
    // present at reset release is absorbed instead of producing a step.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            cnt_q      <= '0;
            led_q      <= LED_LSB;
            pulse_q    <= 1'b0;
            cur_mode_q <= MODE_LEFT;
            dir_q      <= DIR_UP;
        end else begin
            s1_q       <= tick_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
            pulse_q    <= pulse_d;
            cur_mode_q <= cur_mode_d;
            dir_q      <= dir_d;
        end
    end

    always_comb begin
        cnt_d      = startup_done ? cnt_q : cnt_q + 1'b1;
        led_d      = led_q;
        pulse_d    = 1'b0;
        cur_mode_d = cur_mode_q;
        dir_d      = dir_q;

        if (step_apply) begin
            pulse_d = 1'b1;
            if (mode_in != cur_mode_q) begin
                // A mode change spends the step on reinitialising the pattern.
                cur_mode_d = mode_in;
                case (mode_in)
                    MODE_LEFT:   led_d = LED_LSB;
                    MODE_RIGHT:  led_d = LED_MSB;
                    MODE_BOUNCE: begin
                        led_d = LED_LSB;
                        dir_d = DIR_UP;
                    end
                    MODE_BLINK:  led_d = LED_ALL;
                    default:     led_d = LED_LSB;
                endcase
            end else begin
                case (cur_mode_q)
                    MODE_LEFT:   led_d = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
                    MODE_RIGHT:  led_d = {led_q[0], led_q[LED_NUM-1:1]};
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (led_q[LED_NUM-1]) begin
                                led_d = led_q >> 1;
                                dir_d = DIR_DOWN;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_d = led_q << 1;
                                dir_d = DIR_UP;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    MODE_BLINK:  led_d = (|led_q) ? '0 : LED_ALL;
                    default:     led_d = led_q;
                endcase
            end
        end
    end

    assign led_out    = led_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl (LED_NUM=4): expected patterns and arrival cycles
// are queued when a tick is driven and checked when step_pulse appears.
module tb_led_flow_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       tick_in;
    logic [1:0] mode;
    logic       pause;
    logic [3:0] led_out;
    logic       step_pulse;

    typedef struct {
        logic [3:0] led;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    led_flow_ctrl #(.LED_NUM(4), .STARTUP_CYC(3)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .tick_in    (tick_in),
        .mode       (mode),
        .pause      (pause),
        .led_out    (led_out),
        .step_pulse (step_pulse)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    // Every step_pulse must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (step_pulse) begin
            exp_t e;
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_step: step_pulse=1 at cycle %0d led_out=%b, required no step", cyc, led_out);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                assert (led_out === e.led) else begin
                    n_err++;
                    $error("FAIL step_led: observed %b expected %b", led_out, e.led);
                end
                n_cmp++;
                assert (cyc === e.cyc) else begin
                    n_err++;
                    $error("FAIL step_latency: observed cycle %0d expected cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check_led(input string tag, input logic [3:0] exp_led);
        n_cmp++;
        assert (led_out === exp_led) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, led_out, exp_led);
        end
    endtask

    task automatic check_pulse(input string tag, input logic exp_p);
        n_cmp++;
        assert (step_pulse === exp_p) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, step_pulse, exp_p);
        end
    endtask

    // Toggle tick_in; the step lands on the 3rd posedge after the drive.
    task automatic do_tick(input string tag, input logic exp_step, input logic [3:0] exp_led);
        @(negedge sys_clk);
        tick_in = ~tick_in;
        if (exp_step) sb.push_back('{exp_led, cyc + 3});
        repeat (10) @(negedge sys_clk);
        check_led(tag, exp_led);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (6) @(negedge sys_clk);
    endtask

    logic [3:0] left_exp   [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] bounce_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] blink_exp  [3] = '{4'b1111, 4'b0000, 4'b1111};

    initial begin
        sys_rst = 1'b1;
        tick_in = 1'b0;
        mode    = 2'b00;
        pause   = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_led("reset_led", 4'b0001);
        check_pulse("reset_pulse", 1'b0);
        sys_rst = 1'b0;
        repeat (6) @(negedge sys_clk);
        check_led("post_reset_led", 4'b0001);

        // LEFT rotation with wrap
        for (int i = 0; i < 5; i++) do_tick("left", 1'b1, left_exp[i]);

        // Paused ticks are dropped and not queued
        do_reset();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) do_tick("pause_hold", 1'b0, 4'b0001);
        pause = 1'b0;
        do_tick("pause_release", 1'b1, 4'b0010);

        // BOUNCE from reset: first step reinitialises
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 8; i++) do_tick("bounce", 1'b1, bounce_exp[i]);

        // BLINK, then RIGHT reinit and one rotation
        mode = 2'b11;
        for (int i = 0; i < 3; i++) do_tick("blink", 1'b1, blink_exp[i]);
        mode = 2'b01;
        do_tick("right_reinit", 1'b1, 4'b1000);
        do_tick("right_rotate", 1'b1, 4'b0100);

        // Mode change while paused applies on the first step after release
        pause = 1'b1;
        mode  = 2'b00;
        do_tick("pause_mode_hold", 1'b0, 4'b0100);
        pause = 1'b0;
        do_tick("pause_mode_reinit", 1'b1, 4'b0001);
        do_tick("pause_mode_left", 1'b1, 4'b0010);

        // tick_in high through reset must not produce a step
        @(negedge sys_clk);
        sys_rst = 1'b1;
        tick_in = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        check_led("startup_suppress", 4'b0001);

        // Mid-operation reset one cycle after a toggle
        do_tick("midrst_pre", 1'b1, 4'b0010);
        @(negedge sys_clk);
        tick_in = ~tick_in;
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check_led("midrst_led", 4'b0001);
        check_pulse("midrst_pulse", 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        check_led("midrst_after", 4'b0001);

        repeat (5) @(negedge sys_clk);
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL missing_steps: observed %0d outstanding expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
